// File: rtl/decoder_scan_nto2n_if.sv
// Select/strobe bundle for the N-to-2^N decoder: control inputs from the
// controller side, registered decoded outputs back from the decoder.
interface decoder_scan_nto2n_if #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
);
  localparam int M = 2 ** N;

  logic               en;
  logic [1:0]         mode;
  logic [N-1:0]       sel;
  logic               sel_valid;
  logic [DWELL_W-1:0] dwell;
  logic [M-1:0]       y;
  logic [N-1:0]       cur_idx;
  logic               busy;
  logic               wrap;

  modport master (
    output en,
    output mode,
    output sel,
    output sel_valid,
    output dwell,
    input  y,
    input  cur_idx,
    input  busy,
    input  wrap
  );

  modport slave (
    input  en,
    input  mode,
    input  sel,
    input  sel_valid,
    input  dwell,
    output y,
    output cur_idx,
    output busy,
    output wrap
  );
endinterface

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N decoder with decode, thermometer, self-running scan
// and timed one-shot pulse modes; all outputs come straight from flops.
module decoder_scan_nto2n #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  decoder_scan_nto2n_if.slave bus
);
  localparam int M = 2 ** N;

  typedef enum logic [1:0] {
    MODE_DECODE = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_PULSE  = 2'b11
  } mode_e;

  localparam logic [M-1:0]       BIT0  = {{(M-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]       ONE_N = {{(N-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] ONE_C = {{(DWELL_W-1){1'b0}}, 1'b1};

  mode_e              mode_q, mode_d;
  logic [M-1:0]       y_q, y_d;
  logic [N-1:0]       cur_q, cur_d;
  logic [N-1:0]       idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               run_q, run_d;

  mode_e        mode_in;
  logic [M-1:0] sel_oh;
  logic [N:0]   th_sh;
  logic [M-1:0] th_y;
  logic [N-1:0] idx_inc;
  logic [M-1:0] scan_oh;
  logic         dwell_done;

  assign mode_in = mode_e'(bus.mode);
  assign sel_oh  = BIT0 << bus.sel;

  // Shift width reaches M for sel=M-1, which clears every bit and so
  // yields an all-ones thermometer without overflowing.
  assign th_sh = {1'b0, bus.sel} + {{N{1'b0}}, 1'b1};
  assign th_y  = ~({M{1'b1}} << th_sh);

  assign idx_inc    = idx_q + ONE_N;
  assign scan_oh    = BIT0 << idx_inc;
  assign dwell_done = (cnt_q >= bus.dwell);

  always_comb begin
    mode_d = mode_in;
    y_d    = y_q;
    cur_d  = cur_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    run_d  = run_q;
    wrap_d = 1'b0;
    if (mode_in != mode_q) begin
      y_d    = '0;
      cur_d  = '0;
      idx_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
      run_d  = 1'b0;
    end else if (!bus.en) begin
      y_d    = '0;
      idx_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
      run_d  = 1'b0;
    end else begin
      unique case (mode_in)
        MODE_DECODE: begin
          if (bus.sel_valid) begin
            y_d   = sel_oh;
            cur_d = bus.sel;
          end
        end
        MODE_THERM: begin
          if (bus.sel_valid) begin
            y_d   = th_y;
            cur_d = bus.sel;
          end
        end
        MODE_SCAN: begin
          if (!run_q) begin
            y_d   = BIT0;
            cur_d = '0;
            idx_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
          end else if (dwell_done) begin
            y_d    = scan_oh;
            cur_d  = idx_inc;
            idx_d  = idx_inc;
            cnt_d  = '0;
            wrap_d = &idx_q;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
        MODE_PULSE: begin
          // A request seen while busy (even on the falling edge) is lost.
          if (busy_q) begin
            if (dwell_done) begin
              y_d    = '0;
              busy_d = 1'b0;
            end else begin
              cnt_d = cnt_q + ONE_C;
            end
          end else if (bus.sel_valid) begin
            y_d    = sel_oh;
            cur_d  = bus.sel;
            cnt_d  = '0;
            busy_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_DECODE;
      y_q    <= '0;
      cur_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      y_q    <= y_d;
      cur_q  <= cur_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      wrap_q <= wrap_d;
      run_q  <= run_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.cur_idx = cur_q;
  assign bus.busy    = busy_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Bench for decoder_scan_nto2n: directed scenarios plus random mode/sel
// traffic, all checked against a cycle-level behavioural model.
module tb_decoder_scan_nto2n;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int M  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_scan_nto2n_if #(.N(N), .DWELL_W(DW)) bus ();

  decoder_scan_nto2n #(.N(N), .DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  int m_y, m_cur, m_busy, m_wrap, m_prev;
  int scan_t, p_left;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc_n);
    end
  endtask

  // Scan position is derived from elapsed cycles since the scan started.
  task automatic model_edge();
    int d, s, pos;
    d = int'(bus.dwell);
    s = int'(bus.sel);
    m_wrap = 0;
    if (rst) begin
      m_y = 0; m_cur = 0; m_busy = 0;
      scan_t = -1; p_left = 0; m_prev = 0;
      return;
    end
    if (int'(bus.mode) != m_prev) begin
      m_y = 0; m_cur = 0; m_busy = 0;
      scan_t = -1; p_left = 0;
    end else if (!bus.en) begin
      m_y = 0; m_busy = 0;
      scan_t = -1; p_left = 0;
    end else begin
      case (bus.mode)
        2'b00: if (bus.sel_valid) begin
          m_y = 1 << s; m_cur = s;
        end
        2'b01: if (bus.sel_valid) begin
          m_y = (1 << (s + 1)) - 1; m_cur = s;
        end
        2'b10: begin
          scan_t++;
          pos    = scan_t / (d + 1);
          m_cur  = pos % M;
          m_y    = 1 << m_cur;
          m_wrap = (scan_t > 0 && scan_t % (d + 1) == 0 && m_cur == 0)
                   ? 1 : 0;
        end
        default: begin
          if (p_left > 0) begin
            p_left--;
            if (p_left == 0) begin
              m_y = 0; m_busy = 0;
            end
          end else if (bus.sel_valid) begin
            m_y = 1 << s; m_cur = s; m_busy = 1;
            p_left = d + 1;
          end
        end
      endcase
    end
    m_prev = int'(bus.mode);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    cyc_n++;
    check("y", bus.y, m_y);
    check("cur_idx", bus.cur_idx, m_cur);
    check("busy", bus.busy, m_busy);
    check("wrap", bus.wrap, m_wrap);
    if (bus.mode != 2'b01)
      check("onehot0", $onehot0(bus.y), 1);
  endtask

  task automatic set_mode(input logic [1:0] md, input int d);
    bus.mode  = md;
    bus.dwell = DW'(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w1, w2, hits, waited;
    logic [1:0] nm;
    int nd, len;

    m_y = 0; m_cur = 0; m_busy = 0; m_wrap = 0; m_prev = 0;
    scan_t = -1; p_left = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.mode = 2'b00;
    bus.sel = '0;
    bus.sel_valid = 1'b0;
    bus.dwell = '0;
    cyc();
    cyc();
    check("rst_y", bus.y, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;

    bus.sel = 3'd5; bus.sel_valid = 1'b1;
    cyc();
    check("dec_sel5", bus.y, 8'h20);
    check("dec_cur5", bus.cur_idx, 5);
    bus.sel = 3'd2; bus.sel_valid = 1'b0;
    cyc();
    check("dec_hold", bus.y, 8'h20);

    set_mode(2'b01, 0);
    cyc();
    bus.sel_valid = 1'b1;
    bus.sel = 3'd0; cyc(); check("therm0", bus.y, 8'h01);
    bus.sel = 3'd3; cyc(); check("therm3", bus.y, 8'h0F);
    bus.sel = 3'd7; cyc(); check("therm7", bus.y, 8'hFF);

    set_mode(2'b00, 0);
    bus.sel = 3'd3;
    cyc();
    cyc();
    check("dec_sel3", bus.y, 8'h08);
    bus.sel_valid = 1'b0;
    set_mode(2'b10, 2);
    cyc();
    check("mchg_clear", bus.y, 0);
    cyc();
    check("scan_bit0", bus.y, 8'h01);
    w1 = -1; w2 = -1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (bus.wrap) begin
        if (w1 < 0) w1 = cyc_n;
        else if (w2 < 0) w2 = cyc_n;
      end
    end
    check("scan_period_d2", w2 - w1, 24);

    set_mode(2'b00, 2);
    cyc();
    set_mode(2'b10, 0);
    w1 = -1; w2 = -1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.wrap) begin
        if (w1 < 0) w1 = cyc_n;
        else if (w2 < 0) w2 = cyc_n;
      end
    end
    check("scan_period_d0", w2 - w1, 8);

    set_mode(2'b00, 0);
    cyc();
    set_mode(2'b10, 1);
    waited = 0;
    do begin
      cyc();
      waited++;
    end while (bus.cur_idx != 3'd4 && waited < 100);
    check("scan_idx4_reached", bus.cur_idx, 4);
    bus.en = 1'b0;
    cyc();
    check("en_low_y", bus.y, 0);
    bus.en = 1'b1;
    cyc();
    check("en_resume_y", bus.y, 8'h01);
    check("en_resume_cur", bus.cur_idx, 0);

    set_mode(2'b11, 3);
    cyc();
    bus.sel = 3'd6; bus.sel_valid = 1'b1;
    cyc();
    hits = (bus.y == 8'h40) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      bus.sel_valid = (i == 1);
      bus.sel = (i == 1) ? 3'd1 : 3'd6;
      cyc();
      if (bus.y == 8'h40) hits++;
    end
    check("pulse_len", hits, 4);
    check("pulse_end_y", bus.y, 0);

    bus.sel = 3'd2; bus.sel_valid = 1'b1;
    cyc();
    bus.sel_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_pulse_y", bus.y, 0);
    check("rst_pulse_busy", bus.busy, 0);
    rst = 1'b0;

    for (int seg = 0; seg < 40; seg++) begin
      nm  = 2'($urandom_range(0, 3));
      nd  = $urandom_range(0, 4);
      len = $urandom_range(5, 40);
      if (nm == bus.mode) nd = int'(bus.dwell);
      set_mode(nm, nd);
      for (int i = 0; i < len; i++) begin
        bus.sel       = 3'($urandom_range(0, 7));
        bus.sel_valid = 1'($urandom_range(0, 1));
        bus.en        = ($urandom_range(0, 19) != 0);
        rst           = ($urandom_range(0, 99) == 0);
        cyc();
      end
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
